bus_tx_ctrl: RTL and testbench
==============================

Name: bus_tx_ctrl

Overview:
Transmit controller that sits directly upstream of the 4-bit unidirectional tri-state bus driver. It drives that driver's data input and enable.
- Accepts 4-bit words from a producer over a valid/ready handshake.
- Buffers them in a small FIFO.
- Places each word on the bus with the enable asserted until the receiver acknowledges it or a timeout expires.
- Inserts a fixed idle gap, with the bus released, between transfers.

Parameters:
DEPTH, 4, FIFO depth in words; power of two, minimum 2.
TIMEOUT, 8, maximum DRIVE cycles waiting for bus_ack; minimum 1.
GAP, 1, cycles with bus_en low after each transfer; minimum 1.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_data  input  4  word from producer.
in_valid  input  1  producer has a word.
in_ready  output  1  FIFO can accept a word.
bus_data  output  4  data to bus driver data input.
bus_en  output  1  enable to bus driver; 1 drives the bus, 0 releases it to Z.
bus_ack  input  1  receiver has captured bus_data.
tx_done  output  1  one-cycle pulse: word acknowledged.
tx_err  output  1  one-cycle pulse: word dropped on timeout.
fifo_count  output  clog2(DEPTH)+1  words currently buffered.

Behaviour:
Interface: one clock, clk. Reset rst_n is asynchronous and active-low.

Reset (rst_n low, effective immediately):
- FIFO emptied; fifo_count=0.
- State IDLE; all counters 0.
- bus_en=0, bus_data=0, tx_done=0, tx_err=0.
- in_ready=0 while rst_n is low.
- Reset mid-DRIVE drops the word in flight, with no tx_done or tx_err.

FIFO:
- in_ready = rst_n & (fifo_count != DEPTH), combinational.
- Push when in_valid & in_ready at a rising edge.
- Pop only on the IDLE->DRIVE transition.
- Simultaneous push and pop: fifo_count unchanged, both happen.
- Full: in_ready=0, in_data ignored, no overwrite.
- Pointers wrap modulo DEPTH.

State machine (registered outputs):
- IDLE:
  - bus_en=0, bus_data=0.
  - If fifo_count>0: next edge loads the head into bus_data, sets bus_en=1, clears the wait counter, pops, and enters DRIVE.
  - A word pushed into an empty FIFO at edge E0 is on the bus with bus_en=1 after edge E1.
- DRIVE:
  - bus_en=1; bus_data held stable.
  - bus_ack sampled 1 at an edge: go to GAP and pulse tx_done for one cycle.
  - Otherwise, if the wait counter equals TIMEOUT-1: go to GAP and pulse tx_err for one cycle.
  - Otherwise increment the wait counter.
  - bus_ack high on the edge entering DRIVE is not counted; ack is sampled only while in DRIVE.
  - Ack and timeout on the same edge: ack wins (tx_done, not tx_err).
- GAP:
  - bus_en=0, bus_data=0.
  - Stays GAP cycles, then returns to IDLE.
  - bus_ack is ignored.

Throughput and ordering:
- Back-to-back words: minimum period is 1 DRIVE + GAP + 1 IDLE cycle.
- Words leave in FIFO order.
- tx_done and tx_err are never high together.

Invariant: bus_data=0 whenever bus_en=0.

Test Plan:
1. Reset, push 0xA with in_valid for one cycle, bus_ack tied high -> bus_en=1 with bus_data=0xA one edge after acceptance. Held one cycle, tx_done pulse, bus_en=0 for 1 GAP cycle, fifo_count back to 0.
2. Push 0x1,0x2,0x3,0x4,0x5 on consecutive cycles, bus_ack low -> 0x1 moves to the bus and frees a slot, so 0x5 is accepted. in_ready then drops, with fifo_count=4 (0x2..0x5).
3. Release bus_ack while 0x1 is on the bus -> bus_en stays high for exactly 8 cycles, then tx_err pulses once and 0x1 is dropped. Next word 0x2 appears after GAP+1 cycles.
4. Assert bus_ack on the same edge the wait counter reaches 7 -> tx_done=1, tx_err=0.
5. Push one word per cycle while the FIFO drains with ack always high -> simultaneous push/pop keeps fifo_count constant. All words are output in order, with no loss or duplication.
6. Assert rst_n low mid-DRIVE with 3 words buffered -> bus_en=0, bus_data=0 and fifo_count=0 immediately, with no pulses. After release, in_ready=1 and the next pushed word transfers normally.

Source files
------------

// File: rtl/bus_tx_ctrl.sv
// Transmit controller feeding a 4-bit tri-state bus driver.
// Buffers producer words and drives them with ack/timeout and idle gap.
module bus_tx_ctrl #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 8,
   parameter int GAP     = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [3:0]              in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [3:0]              bus_data,
   output logic                    bus_en,
   input  logic                    bus_ack,
   output logic                    tx_done,
   output logic                    tx_err,
   output logic [$clog2(DEPTH):0]  fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int WW = $clog2(TIMEOUT) + 1;
   localparam int GW = $clog2(GAP) + 1;
   localparam logic [AW:0]   FULL   = (AW + 1)'(DEPTH);
   localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT - 1);
   localparam logic [GW-1:0] G_LAST = GW'(GAP - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_GAP
   } state_t;

   state_t        state, state_n;
   logic [WW-1:0] wcnt, wcnt_n;
   logic [GW-1:0] gcnt, gcnt_n;
   logic [3:0]    data_n;
   logic          en_n, done_n, err_n;

   logic [3:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push, pop;

   assign in_ready = rst_n & (fifo_count != FULL);
   assign push     = in_valid & in_ready;
   assign pop      = (state == S_IDLE) & (fifo_count != '0);

   // FIFO storage, pointers (power-of-two wrap) and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // State, counters and registered bus outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         wcnt     <= '0;
         gcnt     <= '0;
         bus_en   <= 1'b0;
         bus_data <= '0;
         tx_done  <= 1'b0;
         tx_err   <= 1'b0;
      end else begin
         state    <= state_n;
         wcnt     <= wcnt_n;
         gcnt     <= gcnt_n;
         bus_en   <= en_n;
         bus_data <= data_n;
         tx_done  <= done_n;
         tx_err   <= err_n;
      end
   end

   // Next state and next registered outputs; bus released unless driving
   always_comb begin
      state_n = state;
      wcnt_n  = wcnt;
      gcnt_n  = gcnt;
      en_n    = 1'b0;
      data_n  = '0;
      done_n  = 1'b0;
      err_n   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (pop) begin
               state_n = S_DRIVE;
               en_n    = 1'b1;
               data_n  = mem[rd_ptr];
               wcnt_n  = '0;
            end
         end
         S_DRIVE: begin
            en_n   = 1'b1;
            data_n = bus_data;
            if (bus_ack) begin
               state_n = S_GAP;
               en_n    = 1'b0;
               data_n  = '0;
               done_n  = 1'b1;
               gcnt_n  = '0;
            end else if (wcnt == W_LAST) begin
               state_n = S_GAP;
               en_n    = 1'b0;
               data_n  = '0;
               err_n   = 1'b1;
               gcnt_n  = '0;
            end else begin
               wcnt_n = wcnt + 1'b1;
            end
         end
         S_GAP: begin
            if (gcnt == G_LAST) state_n = S_IDLE;
            else gcnt_n = gcnt + 1'b1;
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_bus_tx_ctrl.sv
// Directed self-checking bench for bus_tx_ctrl.
// Default parameters: DEPTH=4, TIMEOUT=8, GAP=1.
module tb_bus_tx_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] bus_data;
   logic       bus_en;
   logic       bus_ack;
   logic       tx_done;
   logic       tx_err;
   logic [2:0] fifo_count;

   int total = 0;
   int bad   = 0;
   int drive_cycles = 0;

   bus_tx_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .bus_data   (bus_data),
      .bus_en     (bus_en),
      .bus_ack    (bus_ack),
      .tx_done    (tx_done),
      .tx_err     (tx_err),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_data = '0; in_valid = 1'b0; bus_ack = 1'b0;
      tick; tick;
      total++; if (bus_en !== 1'b0) begin bad++; $display("FAIL rst_en: got %0b want 0", bus_en); end
      total++; if (bus_data !== 4'h0) begin bad++; $display("FAIL rst_data: got %0h want 0", bus_data); end
      total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %0b want 0", in_ready); end
      total++; if ({tx_done, tx_err} !== 2'b00) begin bad++; $display("FAIL rst_pulses: got %0b want 00", {tx_done, tx_err}); end
      rst_n = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_rel_ready: got %0b want 1", in_ready); end
   endtask

   task automatic test_single;
      in_data = 4'hA; in_valid = 1'b1; bus_ack = 1'b1;
      tick;
      in_valid = 1'b0;
      total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL t1_cnt_push: got %0d want 1", fifo_count); end
      total++; if (bus_en !== 1'b0) begin bad++; $display("FAIL t1_en_early: got %0b want 0", bus_en); end
      tick;
      total++; if ({bus_en, bus_data} !== 5'h1A) begin bad++; $display("FAIL t1_drive: got %0h want 1a", {bus_en, bus_data}); end
      total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL t1_cnt_pop: got %0d want 0", fifo_count); end
      tick;
      total++; if ({tx_done, tx_err} !== 2'b10) begin bad++; $display("FAIL t1_done: got %0b want 10", {tx_done, tx_err}); end
      total++; if ({bus_en, bus_data} !== 5'h00) begin bad++; $display("FAIL t1_gap: got %0h want 00", {bus_en, bus_data}); end
      tick;
      total++; if ({tx_done, bus_en} !== 2'b00) begin bad++; $display("FAIL t1_after: got %0b want 00", {tx_done, bus_en}); end
      bus_ack = 1'b0;
   endtask

   task automatic test_fill;
      for (int i = 1; i <= 5; i++) begin
         in_data = 4'(i); in_valid = 1'b1;
         tick;
         if (bus_en === 1'b1) drive_cycles++;
      end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL t2_ready: got %0b want 0", in_ready); end
      total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL t2_cnt: got %0d want 4", fifo_count); end
      total++; if ({bus_en, bus_data} !== 5'h11) begin bad++; $display("FAIL t2_head: got %0h want 11", {bus_en, bus_data}); end
      in_data = 4'h6;
      tick;
      if (bus_en === 1'b1) drive_cycles++;
      in_valid = 1'b0;
      total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL t2_full_push: got %0d want 4", fifo_count); end
   endtask

   task automatic test_timeout;
      int n;
      n = 0;
      while (bus_en === 1'b1 && n < 20) begin
         total++; if (tx_err !== 1'b0) begin bad++; $display("FAIL t3_err_early: got %0b want 0", tx_err); end
         tick;
         n++;
         if (bus_en === 1'b1) drive_cycles++;
      end
      total++; if (drive_cycles !== 8) begin bad++; $display("FAIL t3_drive_len: got %0d want 8", drive_cycles); end
      total++; if ({tx_done, tx_err} !== 2'b01) begin bad++; $display("FAIL t3_err: got %0b want 01", {tx_done, tx_err}); end
      total++; if ({bus_en, bus_data} !== 5'h00) begin bad++; $display("FAIL t3_gap: got %0h want 00", {bus_en, bus_data}); end
      tick;
      total++; if ({tx_err, bus_en} !== 2'b00) begin bad++; $display("FAIL t3_idle: got %0b want 00", {tx_err, bus_en}); end
      tick;
      total++; if ({bus_en, bus_data} !== 5'h12) begin bad++; $display("FAIL t3_next: got %0h want 12", {bus_en, bus_data}); end
      total++; if (fifo_count !== 3'd3) begin bad++; $display("FAIL t3_cnt: got %0d want 3", fifo_count); end
   endtask

   task automatic test_ack_at_timeout;
      for (int i = 0; i < 7; i++) begin
         tick;
         total++; if (bus_en !== 1'b1) begin bad++; $display("FAIL t4_hold%0d: got %0b want 1", i, bus_en); end
      end
      bus_ack = 1'b1;
      tick;
      total++; if ({tx_done, tx_err} !== 2'b10) begin bad++; $display("FAIL t4_ack_wins: got %0b want 10", {tx_done, tx_err}); end
   endtask

   task automatic test_back_to_back;
      logic [3:0] exp_q [$];
      logic [3:0] w;
      exp_q = '{4'h3, 4'h4, 4'h5};
      for (int k = 0; k < 5; k++) begin
         tick;
         total++; if (bus_en !== 1'b0) begin bad++; $display("FAIL t5_idle%0d: got %0b want 0", k, bus_en); end
         in_data = 4'(6 + k); in_valid = 1'b1;
         exp_q.push_back(4'(6 + k));
         tick;
         in_valid = 1'b0;
         w = exp_q.pop_front();
         total++; if (fifo_count !== 3'd3) begin bad++; $display("FAIL t5_cnt%0d: got %0d want 3", k, fifo_count); end
         total++; if ({bus_en, bus_data} !== {1'b1, w}) begin bad++; $display("FAIL t5_word%0d: got %0h want %0h", k, {bus_en, bus_data}, {1'b1, w}); end
         tick;
         total++; if (tx_done !== 1'b1) begin bad++; $display("FAIL t5_done%0d: got %0b want 1", k, tx_done); end
      end
   endtask

   task automatic test_reset_mid_drive;
      bus_ack = 1'b0;
      tick;
      in_data = 4'hB; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      total++; if ({bus_en, bus_data} !== 5'h18) begin bad++; $display("FAIL t6_drive: got %0h want 18", {bus_en, bus_data}); end
      total++; if (fifo_count !== 3'd3) begin bad++; $display("FAIL t6_cnt: got %0d want 3", fifo_count); end
      tick; tick;
      rst_n = 1'b0;
      #1;
      total++; if ({bus_en, bus_data} !== 5'h00) begin bad++; $display("FAIL t6_rst_bus: got %0h want 00", {bus_en, bus_data}); end
      total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL t6_rst_cnt: got %0d want 0", fifo_count); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL t6_rst_ready: got %0b want 0", in_ready); end
      for (int i = 0; i < 2; i++) begin
         tick;
         total++; if ({tx_done, tx_err, bus_en} !== 3'b000) begin bad++; $display("FAIL t6_quiet%0d: got %0b want 000", i, {tx_done, tx_err, bus_en}); end
      end
      rst_n = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL t6_rel_ready: got %0b want 1", in_ready); end
      in_data = 4'hC; in_valid = 1'b1; bus_ack = 1'b1;
      tick;
      in_valid = 1'b0;
      tick;
      total++; if ({bus_en, bus_data} !== 5'h1C) begin bad++; $display("FAIL t6_post: got %0h want 1c", {bus_en, bus_data}); end
      tick;
      total++; if ({tx_done, tx_err} !== 2'b10) begin bad++; $display("FAIL t6_post_done: got %0b want 10", {tx_done, tx_err}); end
      bus_ack = 1'b0;
   endtask

   initial begin
      test_reset;
      test_single;
      test_fill;
      test_timeout;
      test_ack_at_timeout;
      test_back_to_back;
      test_reset_mid_drive;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
